// File: rtl/icache_prefetch_controller.sv
// I-cache fill controller: demand line fills from L2 one word per beat, followed by an
// optional, abortable next-line prefetch.
package icache_prefetch_pkg;

  typedef enum logic {
    ICACHE_READ    = 1'b0,
    ICACHE_CLFLUSH = 1'b1
  } icache_memory_operation_e;

  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    STORE = 2'b01
  } memory_operation_e;

endpackage

module icache_prefetch_controller
  import icache_prefetch_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter bit          PREFETCH_EN    = 1'b1,
  parameter int unsigned PF_CNT_W       = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                pipe_req_valid,
  input  icache_memory_operation_e            pipe_req_type,
  input  logic [ADDR_W-1:0]                   pipe_req_addr,
  output logic                                pipe_req_fulfilled,
  output logic                                l2_req_valid,
  output memory_operation_e                   l2_req_type,
  output logic [ADDR_W-1:0]                   l2_req_addr,
  input  logic                                l2_req_fulfilled,
  input  logic                                valid_block_match,
  input  logic                                pf_block_match,
  output logic                                load_mode,
  output logic                                perform_write,
  output logic [ADDR_W-1:0]                   fill_addr,
  output logic [$clog2(WORDS_PER_LINE)-1:0]   fill_word_idx,
  output logic                                clear_selected_valid_bit,
  output logic                                finish_new_line_install,
  output logic [PF_CNT_W-1:0]                 pf_count
);

  localparam int unsigned IDX_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned OFF_W = IDX_W + 2;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StAlloc    = 2'd1;
  localparam logic [1:0] StPfProbe  = 2'd2;
  localparam logic [1:0] StPrefetch = 2'd3;

  localparam logic [ADDR_W:0] LineBytes = {{(ADDR_W - OFF_W){1'b0}}, 1'b1, {OFF_W{1'b0}}};

  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   fill_line_q, fill_line_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PF_CNT_W-1:0] pf_count_q, pf_count_d;

  logic [ADDR_W:0]     next_line_sum;
  logic                next_line_wraps;
  logic [ADDR_W-1:0]   miss_line;
  logic                last_beat;
  logic                unused_addr_offset;

  // Byte offset within the line is irrelevant to the controller.
  assign unused_addr_offset = ^pipe_req_addr[OFF_W-1:0];

  assign next_line_sum   = {1'b0, fill_line_q} + LineBytes;
  assign next_line_wraps = next_line_sum[ADDR_W];
  assign miss_line       = {pipe_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign last_beat       = &idx_q;

  // idx is zero whenever the FSM is idle, so this equals fill_line outside a fill.
  assign fill_addr     = fill_line_q | {{(ADDR_W - OFF_W){1'b0}}, idx_q, 2'b00};
  assign fill_word_idx = idx_q;
  assign pf_count      = pf_count_q;

  always_comb begin
    state_d     = state_q;
    fill_line_d = fill_line_q;
    idx_d       = idx_q;
    pf_count_d  = pf_count_q;

    pipe_req_fulfilled       = 1'b0;
    l2_req_valid             = 1'b0;
    l2_req_type              = LOAD;
    l2_req_addr              = fill_addr;
    load_mode                = 1'b0;
    perform_write            = 1'b0;
    clear_selected_valid_bit = 1'b0;
    finish_new_line_install  = 1'b0;

    case (state_q)
      StIdle: begin
        if (pipe_req_valid) begin
          if (pipe_req_type == ICACHE_CLFLUSH) begin
            pipe_req_fulfilled       = 1'b1;
            clear_selected_valid_bit = valid_block_match;
          end else if (valid_block_match) begin
            pipe_req_fulfilled = 1'b1;
          end else begin
            fill_line_d = miss_line;
            idx_d       = '0;
            state_d     = StAlloc;
          end
        end
      end

      StAlloc, StPrefetch: begin
        l2_req_valid = 1'b1;
        load_mode    = 1'b1;
        if (l2_req_fulfilled) begin
          perform_write = 1'b1;
          idx_d         = idx_q + IDX_W'(1);
          if (last_beat) begin
            finish_new_line_install = 1'b1;
            // Advance the base here so the probe cycle already looks up the next line.
            if (state_q == StAlloc && PREFETCH_EN && !next_line_wraps) begin
              fill_line_d = next_line_sum[ADDR_W-1:0];
              state_d     = StPfProbe;
            end else begin
              state_d = StIdle;
            end
          end else if (state_q == StPrefetch && pipe_req_valid) begin
            // Abort: the partial line is left invalid and the pipeline replays in idle.
            idx_d   = '0;
            state_d = StIdle;
          end
        end
      end

      StPfProbe: begin
        if (pf_block_match) begin
          state_d = StIdle;
        end else begin
          idx_d   = '0;
          state_d = StPrefetch;
          if (!(&pf_count_q)) begin
            pf_count_d = pf_count_q + PF_CNT_W'(1);
          end
        end
      end

      default: begin
        state_d                  = 'x;
        fill_line_d              = 'x;
        idx_d                    = 'x;
        pf_count_d               = 'x;
        pipe_req_fulfilled       = 1'bx;
        l2_req_valid             = 1'bx;
        l2_req_type              = memory_operation_e'('x);
        l2_req_addr              = 'x;
        load_mode                = 1'bx;
        perform_write            = 1'bx;
        clear_selected_valid_bit = 1'bx;
        finish_new_line_install  = 1'bx;
      end
    endcase

    if (!reset) begin
      pipe_req_fulfilled       = 1'b0;
      l2_req_valid             = 1'b0;
      l2_req_type              = LOAD;
      load_mode                = 1'b0;
      perform_write            = 1'b0;
      clear_selected_valid_bit = 1'b0;
      finish_new_line_install  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      fill_line_q <= '0;
      idx_q       <= '0;
      pf_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      fill_line_q <= fill_line_d;
      idx_q       <= idx_d;
      pf_count_q  <= pf_count_d;
    end
  end

endmodule

// File: tb/tb_icache_prefetch_controller.sv
// Bench for icache_prefetch_controller: table-driven idle decoding plus scoreboarded L2 fills.
module tb_icache_prefetch_controller;
  import icache_prefetch_pkg::*;

  localparam int unsigned WPL = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic                     pipe_req_valid = 1'b0;
  icache_memory_operation_e pipe_req_type = ICACHE_READ;
  logic [31:0]              pipe_req_addr = '0;
  logic                     l2_req_fulfilled = 1'b0;
  logic                     valid_block_match = 1'b0;
  logic                     pf_block_match = 1'b0;

  logic              pipe_req_fulfilled, l2_req_valid, load_mode, perform_write;
  logic              clear_selected_valid_bit, finish_new_line_install;
  memory_operation_e l2_req_type;
  logic [31:0]       l2_req_addr, fill_addr;
  logic [1:0]        fill_word_idx;
  logic [15:0]       pf_count;

  logic              np_pipe_req_fulfilled, np_l2_req_valid, np_load_mode, np_perform_write;
  logic              np_clear_selected_valid_bit, np_finish_new_line_install;
  memory_operation_e np_l2_req_type;
  logic [31:0]       np_l2_req_addr, np_fill_addr;
  logic [1:0]        np_fill_word_idx;
  logic [15:0]       np_pf_count;

  icache_prefetch_controller #(
    .WORDS_PER_LINE(WPL), .ADDR_W(32), .PREFETCH_EN(1'b1), .PF_CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .pipe_req_valid(pipe_req_valid), .pipe_req_type(pipe_req_type),
    .pipe_req_addr(pipe_req_addr), .pipe_req_fulfilled(pipe_req_fulfilled),
    .l2_req_valid(l2_req_valid), .l2_req_type(l2_req_type), .l2_req_addr(l2_req_addr),
    .l2_req_fulfilled(l2_req_fulfilled), .valid_block_match(valid_block_match),
    .pf_block_match(pf_block_match), .load_mode(load_mode), .perform_write(perform_write),
    .fill_addr(fill_addr), .fill_word_idx(fill_word_idx),
    .clear_selected_valid_bit(clear_selected_valid_bit),
    .finish_new_line_install(finish_new_line_install), .pf_count(pf_count)
  );

  icache_prefetch_controller #(
    .WORDS_PER_LINE(WPL), .ADDR_W(32), .PREFETCH_EN(1'b0), .PF_CNT_W(16)
  ) dut_np (
    .clk(clk), .reset(reset),
    .pipe_req_valid(pipe_req_valid), .pipe_req_type(pipe_req_type),
    .pipe_req_addr(pipe_req_addr), .pipe_req_fulfilled(np_pipe_req_fulfilled),
    .l2_req_valid(np_l2_req_valid), .l2_req_type(np_l2_req_type),
    .l2_req_addr(np_l2_req_addr), .l2_req_fulfilled(l2_req_fulfilled),
    .valid_block_match(valid_block_match), .pf_block_match(pf_block_match),
    .load_mode(np_load_mode), .perform_write(np_perform_write), .fill_addr(np_fill_addr),
    .fill_word_idx(np_fill_word_idx),
    .clear_selected_valid_bit(np_clear_selected_valid_bit),
    .finish_new_line_install(np_finish_new_line_install), .pf_count(np_pf_count)
  );

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] addr;
    logic        fin;
  } beat_t;
  beat_t sb[$];

  typedef struct {
    logic                     v;
    icache_memory_operation_e t;
    logic                     vbm;
    logic                     ful;
    logic                     clr;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic miss(input logic [31:0] a);
    @(posedge clk); #1;
    pipe_req_valid    = 1'b1;
    pipe_req_type     = ICACHE_READ;
    pipe_req_addr     = a;
    valid_block_match = 1'b0;
    l2_req_fulfilled  = 1'b0;
    @(negedge clk);
    chk("miss_no_fulfil", pipe_req_fulfilled, 1'b0);
    chk("miss_no_l2", l2_req_valid, 1'b0);
  endtask

  // L2 answers every second cycle; abort_beat >= 0 raises a pipe hit from that beat on.
  task automatic serve_line(input logic [31:0] base, input int abort_beat);
    int  last_b = (abort_beat >= 0) ? abort_beat : int'(WPL) - 1;
    int  beat = 0;
    int  budget = 0;
    bit  phase = 1'b0;
    for (int b = 0; b <= last_b; b++)
      sb.push_back('{base + 32'(b * 4), (abort_beat < 0) && (b == int'(WPL) - 1)});
    while (sb.size() > 0 && budget < 40) begin
      @(posedge clk); #1;
      l2_req_fulfilled  = phase;
      pipe_req_valid    = (abort_beat >= 0) && (beat >= abort_beat);
      pipe_req_type     = ICACHE_READ;
      valid_block_match = 1'b1;
      @(negedge clk);
      chk("l2_valid", l2_req_valid, 1'b1);
      chk("l2_type", l2_req_type, LOAD);
      chk("l2_addr", l2_req_addr, sb[0].addr);
      chk("load_mode", load_mode, 1'b1);
      chk("word_idx", fill_word_idx, beat);
      chk("busy_no_fulfil", pipe_req_fulfilled, 1'b0);
      chk("write", perform_write, phase);
      if (phase) begin
        chk("finish", finish_new_line_install, sb[0].fin);
        void'(sb.pop_front());
        beat++;
      end else begin
        chk("finish_wait", finish_new_line_install, 1'b0);
      end
      phase = !phase;
      budget++;
    end
    if (sb.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL fill_timeout: %0d beats outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic probe(input logic pfm, input logic [31:0] exp_fa);
    @(posedge clk); #1;
    l2_req_fulfilled = 1'b0;
    pipe_req_valid   = 1'b0;
    pf_block_match   = pfm;
    @(negedge clk);
    chk("probe_l2", l2_req_valid, 1'b0);
    chk("probe_fill_addr", fill_addr, exp_fa);
  endtask

  task automatic idle_check(input logic [31:0] exp_fa, input logic [15:0] exp_cnt);
    @(posedge clk); #1;
    l2_req_fulfilled = 1'b0;
    pipe_req_valid   = 1'b0;
    @(negedge clk);
    chk("idle_l2", l2_req_valid, 1'b0);
    chk("idle_fill_addr", fill_addr, exp_fa);
    chk("idle_pf_count", pf_count, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, ICACHE_READ,    1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, ICACHE_CLFLUSH, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b1, ICACHE_CLFLUSH, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, ICACHE_READ,    1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, ICACHE_CLFLUSH, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, ICACHE_READ,    1'b1, 1'b0, 1'b0};

    // Reset held with a flush request present: outputs must stay quiet.
    pipe_req_valid    = 1'b1;
    pipe_req_type     = ICACHE_CLFLUSH;
    valid_block_match = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fulfil", pipe_req_fulfilled, 1'b0);
    chk("rst_clear", clear_selected_valid_bit, 1'b0);
    chk("rst_l2", l2_req_valid, 1'b0);
    chk("rst_pf_count", pf_count, 16'd0);
    chk("rst_fill_addr", fill_addr, 32'd0);
    chk("rst_l2_type", l2_req_type, LOAD);
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      pipe_req_valid    = vecs[i].v;
      pipe_req_type     = vecs[i].t;
      pipe_req_addr     = 32'h0000_0040;
      valid_block_match = vecs[i].vbm;
      @(negedge clk);
      chk("vec_fulfil", pipe_req_fulfilled, vecs[i].ful);
      chk("vec_clear", clear_selected_valid_bit, vecs[i].clr);
      chk("vec_l2", l2_req_valid, 1'b0);
      chk("vec_write", perform_write, 1'b0);
    end

    // Demand fill then prefetch of the next line.
    miss(32'h0000_1008);
    serve_line(32'h0000_1000, -1);
    probe(1'b0, 32'h0000_1010);
    chk("np_no_probe_addr", np_fill_addr, 32'h0000_1000);
    chk("probe_cnt_before", pf_count, 16'd0);
    serve_line(32'h0000_1010, -1);
    chk("np_no_prefetch", np_l2_req_valid, 1'b0);
    idle_check(32'h0000_1010, 16'd1);
    idle_check(32'h0000_1010, 16'd1);

    // Prefetch aborted at beat 1; the held pipe hit is serviced next cycle.
    miss(32'h0000_2000);
    serve_line(32'h0000_2000, -1);
    probe(1'b0, 32'h0000_2010);
    serve_line(32'h0000_2010, 1);
    @(posedge clk); #1;
    l2_req_fulfilled = 1'b0;
    @(negedge clk);
    chk("abort_replay_fulfil", pipe_req_fulfilled, 1'b1);
    chk("abort_l2", l2_req_valid, 1'b0);
    chk("abort_fill_addr", fill_addr, 32'h0000_2010);
    chk("abort_pf_count", pf_count, 16'd2);

    // Last line of the address space: no next-line probe.
    pf_block_match = 1'b0;
    miss(32'hFFFF_FFF4);
    serve_line(32'hFFFF_FFF0, -1);
    idle_check(32'hFFFF_FFF0, 16'd2);
    idle_check(32'hFFFF_FFF0, 16'd2);

    // Next line already present: prefetch dropped.
    miss(32'h0000_5000);
    serve_line(32'h0000_5000, -1);
    probe(1'b1, 32'h0000_5010);
    idle_check(32'h0000_5010, 16'd2);
    chk("np_pf_count", np_pf_count, 16'd0);

    // Reset during beat 2 of a demand fill.
    miss(32'h0000_6000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pipe_req_valid   = 1'b0;
      l2_req_fulfilled = (i % 2) == 1;
      @(negedge clk);
      chk("pre_rst_l2", l2_req_valid, 1'b1);
    end
    @(posedge clk); #1;
    reset            = 1'b0;
    l2_req_fulfilled = 1'b1;
    @(negedge clk);
    chk("mid_rst_l2", l2_req_valid, 1'b0);
    chk("mid_rst_write", perform_write, 1'b0);
    chk("mid_rst_finish", finish_new_line_install, 1'b0);
    @(posedge clk); #1;
    reset            = 1'b1;
    l2_req_fulfilled = 1'b0;
    @(negedge clk);
    chk("post_rst_l2", l2_req_valid, 1'b0);
    chk("post_rst_pf_count", pf_count, 16'd0);
    chk("post_rst_fill_addr", fill_addr, 32'd0);
    chk("post_rst_finish", finish_new_line_install, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
